im_port_arbiter: RTL and testbench

//  Shares the single-ported instruction memory between three requesters: fetch (PC), LWI

---
 rtl/im_port_arbiter.sv | 130 +++++++++++++
 tb/tb_im_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the single-ported IM between fetch, LWI reads and the loader; IM_ARB_PERF_CNT_EN adds perf counters
module im_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int LD_MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              stall_if,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  input  logic              lwi_req,
  input  logic [ADDR_W-1:0] lwi_addr,
  output logic [DATA_W-1:0] lwi_data,
  output logic              lwi_valid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_re,
  output logic              im_we,
  output logic [DATA_W-1:0] im_wdata,
  input  logic [DATA_W-1:0] im_rdata
`ifdef IM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_lwi_cnt
`endif
);
  localparam int CNT_W = $clog2(LD_MAX_BURST + 1);
  typedef enum logic [2:0] {FETCH, LWI_ADDR, LWI_DATA, LOAD, LD_GAP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] lwi_data_q, lwi_data_d;
  logic lwi_valid_q, lwi_valid_d, if_valid_q, fetch_gnt;
  assign if_instr  = im_rdata;
  assign if_valid  = if_valid_q;
  assign lwi_data  = lwi_data_q;
  assign lwi_valid = lwi_valid_q;
  assign im_wdata  = ld_wdata;
  // Port ownership sequencing; a request whose lwi_valid is showing this cycle is already complete
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if    = 1'b1;
    ld_gnt      = 1'b0;
    fetch_gnt   = 1'b0;
    im_addr     = if_addr;
    im_re       = 1'b0;
    im_we       = 1'b0;
    lwi_valid_d = 1'b0;
    lwi_data_d  = lwi_data_q;
    case (state_q)
      FETCH: begin
        if (ld_req) begin
          ld_gnt  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = (LD_MAX_BURST == 1) ? LD_GAP : LOAD;
        end else if (lwi_req && !lwi_valid_q) begin
          state_d = LWI_ADDR;
        end else begin
          stall_if  = 1'b0;
          fetch_gnt = 1'b1;
          im_re     = 1'b1;
        end
      end
      LWI_ADDR: begin
        im_addr = lwi_addr;
        im_re   = 1'b1;
        state_d = LWI_DATA;
      end
      LWI_DATA: begin
        lwi_data_d  = im_rdata;
        lwi_valid_d = 1'b1;
        state_d     = FETCH;
      end
      LOAD: begin
        if (!ld_req) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          ld_gnt  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_W'(LD_MAX_BURST - 1)) ? LD_GAP : LOAD;
        end
      end
      LD_GAP: begin
        cnt_d   = '0;
        state_d = lwi_req ? LWI_ADDR : FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (ld_gnt) begin
      im_addr = ld_addr;
      im_we   = ld_we;
      im_re   = !ld_we;
    end
  end
  // State, burst counter and registered LWI/fetch result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      cnt_q       <= '0;
      lwi_data_q  <= '0;
      lwi_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lwi_data_q  <= lwi_data_d;
      lwi_valid_q <= lwi_valid_d;
      if_valid_q  <= fetch_gnt;
    end
  end
`ifdef IM_ARB_PERF_CNT_EN
  // Saturating counts of stalled cycles and completed LWI reads
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_lwi_cnt   <= '0;
    end else begin
      if (stall_if && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (lwi_valid_q && perf_lwi_cnt != '1) perf_lwi_cnt <= perf_lwi_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter: scoreboard bench for im_port_arbiter with a behavioural IM
module tb_im_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] if_addr = '0, lwi_addr = '0, ld_addr = '0, ld_wdata = '0, im_rdata = '0;
  logic lwi_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic stall_if, if_valid, lwi_valid, ld_gnt, im_re, im_we;
  logic [15:0] if_instr, lwi_data, im_addr, im_wdata;
`ifdef IM_ARB_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_lwi_cnt;
`endif
  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  logic [15:0] sb [$];
  int total = 0, passed = 0;

  im_port_arbiter dut (
    .clk(clk), .rst(rst), .if_addr(if_addr), .stall_if(stall_if), .if_instr(if_instr),
    .if_valid(if_valid), .lwi_req(lwi_req), .lwi_addr(lwi_addr), .lwi_data(lwi_data),
    .lwi_valid(lwi_valid), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .im_addr(im_addr), .im_re(im_re), .im_we(im_we),
    .im_wdata(im_wdata), .im_rdata(im_rdata)
`ifdef IM_ARB_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_lwi_cnt(perf_lwi_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(int i);
    return (i == 64) ? 16'hBEEF : {8'hC0, 8'(i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= dflt(i);
    end else begin
      if (im_we) mem[im_addr[7:0]] <= im_wdata;
      if (im_re) im_rdata <= mem[im_addr[7:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; lwi_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; if_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({stall_if, if_valid, lwi_valid, ld_gnt, im_we, lwi_data} !== 21'd0)
      $display("FAIL reset_outputs: got stall=%b ifv=%b lwiv=%b gnt=%b we=%b data=%h, want all 0",
               stall_if, if_valid, lwi_valid, ld_gnt, im_we, lwi_data);
    else passed++;
    for (int i = 0; i < 256; i++) exp_mem[i] = dflt(i);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if_addr = 16'(i);
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        total++;
        if ({if_valid, if_instr} !== {1'b1, e})
          $display("FAIL fetch_data[%0d]: got valid=%b instr=%h, want valid=1 instr=%h", i, if_valid, if_instr, e);
        else passed++;
      end
      if (i < 5) begin
        total++;
        if ({stall_if, im_re, im_addr} !== {1'b0, 1'b1, 16'(i)})
          $display("FAIL fetch_addr[%0d]: got stall=%b re=%b addr=%h, want 0 1 %h", i, stall_if, im_re, im_addr, 16'(i));
        else passed++;
        sb.push_back(exp_mem[i]);
      end
    end
  endtask

  task automatic test_lwi(input logic [15:0] a);
    logic [15:0] e;
    int stalls = 0, lat = 0;
    bit got = 0;
    @(posedge clk); #1;
    lwi_req = 1'b1; lwi_addr = a;
    sb.push_back(exp_mem[a[7:0]]);
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (stall_if) stalls++;
      if (lwi_valid) begin
        got = 1; lat = c - 1;
        e = sb.pop_front();
        total++;
        if (lwi_data !== e) $display("FAIL lwi_data: got %h, want %h", lwi_data, e);
        else passed++;
      end
      @(posedge clk); #1;
      if (got) lwi_req = 1'b0;
    end
    total++;
    if (!got) begin
      $display("FAIL lwi_timeout: got no lwi_valid, want one within 12 cycles");
      lwi_req = 1'b0;
      void'(sb.pop_front());
    end else passed++;
    total++;
    if (lat != 3 || stalls != 3) $display("FAIL lwi_timing: got latency=%0d stalls=%0d, want 3 3", lat, stalls);
    else passed++;
    @(negedge clk);
    total++;
    if (lwi_valid !== 1'b0) $display("FAIL lwi_pulse: got lwi_valid=%b after pulse, want 0", lwi_valid);
    else passed++;
  endtask

  task automatic test_ld_lwi_same();
    logic [15:0] e;
    int grants = 0;
    bit got = 0;
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0041; ld_wdata = 16'h1234;
    lwi_req = 1'b1; lwi_addr = 16'h0040;
    sb.push_back(exp_mem[8'h40]);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if ({ld_gnt, stall_if, im_we} !== 3'b111) $display("FAIL prio_first: got gnt=%b stall=%b we=%b, want 1 1 1", ld_gnt, stall_if, im_we);
        else passed++;
      end
      if (ld_gnt) begin
        exp_mem[ld_addr[7:0]] = ld_wdata;
        grants++;
      end
      if (lwi_valid) begin
        got = 1;
        e = sb.pop_front();
        total++;
        if ({grants, lwi_data} !== {32'd2, e}) $display("FAIL prio_lwi: got grants=%0d data=%h, want 2 %h", grants, lwi_data, e);
        else passed++;
      end
      @(posedge clk); #1;
      if (grants >= 2) ld_req = 1'b0;
      else if (ld_gnt) begin ld_addr++; ld_wdata++; end
      if (got) lwi_req = 1'b0;
    end
    total++;
    if (!got) begin
      $display("FAIL prio_timeout: got no lwi_valid, want one within 20 cycles");
      lwi_req = 1'b0; ld_req = 1'b0;
      void'(sb.pop_front());
    end else passed++;
  endtask

  task automatic test_burst();
    int runs_exp [$] = '{8, 8, 4};
    int k = 0, run = 0, gap = 0;
    bit pend = 0;
    logic [15:0] e;
    for (int c = 0; c < 60 && k < 20; c++) begin
      @(posedge clk); #1;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0080 + 16'(k); ld_wdata = 16'hD000 + 16'(k);
      @(negedge clk);
      if (ld_gnt) begin
        if (gap > 0) begin
          total++;
          if (gap != 1) $display("FAIL burst_gap: got %0d idle cycles, want 1", gap);
          else passed++;
          gap = 0;
        end
        exp_mem[ld_addr[7:0]] = ld_wdata;
        run++; k++;
      end else if (run > 0) begin
        total++;
        if (run != runs_exp[0]) $display("FAIL burst_run: got run of %0d, want %0d", run, runs_exp[0]);
        else passed++;
        void'(runs_exp.pop_front());
        run = 0; gap = 1;
      end else gap++;
    end
    @(posedge clk); #1;
    ld_req = 1'b0;
    total++;
    if (k != 20 || runs_exp.size() != 1 || run != runs_exp[0])
      $display("FAIL burst_last: got words=%0d last_run=%0d runs_left=%0d, want 20 4 1", k, run, runs_exp.size());
    else passed++;
    k = 0;
    for (int c = 0; c < 70 && (k < 20 || pend); c++) begin
      @(posedge clk); #1;
      ld_req = (k < 20); ld_we = 1'b0; ld_addr = 16'h0080 + 16'(k);
      @(negedge clk);
      if (pend) begin
        e = sb.pop_front();
        total++;
        if (im_rdata !== e) $display("FAIL readback: got %h, want %h", im_rdata, e);
        else passed++;
        pend = 0;
      end
      if (ld_gnt) begin
        sb.push_back(exp_mem[ld_addr[7:0]]);
        pend = 1; k++;
      end
    end
    @(posedge clk); #1;
    ld_req = 1'b0;
    total++;
    if (k != 20) $display("FAIL readback_timeout: got %0d reads, want 20", k);
    else passed++;
    sb.delete();
  endtask

  task automatic test_reset_lwi();
    @(posedge clk); #1;
    lwi_req = 1'b1; lwi_addr = 16'h0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (stall_if !== 1'b1) $display("FAIL rst_lwi_pre: got stall=%b in LWI_DATA, want 1", stall_if);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0; lwi_req = 1'b0; if_addr = 16'h0003;
    @(negedge clk);
    total++;
    if ({lwi_valid, stall_if, im_re, im_addr} !== {1'b0, 1'b0, 1'b1, 16'h0003})
      $display("FAIL rst_lwi: got lwiv=%b stall=%b re=%b addr=%h, want 0 0 1 0003", lwi_valid, stall_if, im_re, im_addr);
    else passed++;
    for (int i = 0; i < 256; i++) exp_mem[i] = dflt(i);
  endtask

`ifdef IM_ARB_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    test_lwi(16'h0040);
    test_lwi(16'h0040);
    total++;
    if (perf_lwi_cnt !== 32'd2 || perf_stall_cnt !== 32'd6)
      $display("FAIL perf_cnt: got lwi=%0d stall=%0d, want 2 6", perf_lwi_cnt, perf_stall_cnt);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_lwi(16'h0040);
    test_ld_lwi_same();
    test_burst();
    test_reset_lwi();
`ifdef IM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
